sfp_link_led_ctrl: RTL
======================

SFP_LINK_LED_CTRL -- requirements
Module: sfp_link_led_ctrl

Interface
REQ-001 The block SHALL have parameter LOCK_DEBOUNCE, default 1024, the number of cycles block_lock must stay high before link_up asserts (range 1..65535).
REQ-002 The block SHALL have parameter BLINK_CYCLES, default 7812500, the length of each activity blink ON phase and OFF phase in clk cycles (range 1..2^24-1).
REQ-003 clk  input  1  Single clock (156.25 MHz SFP0 TX clock); one clock, all logic on its rising edge.
REQ-004 rst_n  input  1  Reset; asynchronous assert, active-low.
REQ-005 block_lock  input  4  Per-port PHY RX block lock, asynchronous to clk.
REQ-006 rx_activity  input  4  Per-port single-cycle activity pulse, synchronous to clk.
REQ-007 drop_cnt_clear  input  1  Single-cycle pulse that clears all drop counters.
REQ-008 link_up  output  4  Per-port debounced link status, registered.
REQ-009 led  output  8  led[3:0] = link_up[3:0]; led[7:4] = per-port activity blink; registered.
REQ-010 drop_cnt  output  32  Per-port saturating link-drop counter; port i occupies bits [8i+7:8i].

Function
REQ-011 Each block_lock bit SHALL pass through a 2-flop synchronizer before use; no other logic SHALL sample block_lock directly.
REQ-012 Debounce, per port: while the synchronized lock is low, the counter SHALL be 0 and link_up SHALL be 0.
REQ-013 Debounce: when block_lock is first sampled high at edge 0 and held high, link_up SHALL assert at edge LOCK_DEBOUNCE+2.
REQ-014 Debounce: any low sample before link_up asserts SHALL restart the count from 0.
REQ-015 Drop: when block_lock is first sampled low at edge 0 while link_up=1, link_up SHALL deassert at edge 2, with no debounce on the falling side.
REQ-016 Drop counter, per port: SHALL increment by 1 on the cycle link_up transitions 1->0, and SHALL saturate at 255 (no wrap).
REQ-017 drop_cnt_clear SHALL zero all four counters on the next edge.
REQ-018 Simultaneous drop_cnt_clear and a drop on a port SHALL yield that port's counter = 1.
REQ-019 Activity FSM per port with states IDLE, ON, OFF; led[4+i] = 1 only in ON.
REQ-020 IDLE -> ON on the edge sampling rx_activity[i]=1 with link_up[i]=1; the led bit SHALL be high in the following cycle.
REQ-021 ON -> OFF after exactly BLINK_CYCLES cycles in ON.
REQ-022 OFF -> IDLE after BLINK_CYCLES cycles, or OFF -> ON if the pending flag is set.
REQ-023 An rx_activity pulse during ON or OFF SHALL set the per-port pending flag (multiple pulses collapse to one); entering ON SHALL clear it.
REQ-024 rx_activity while link_up=0 SHALL be ignored.
REQ-025 link_up falling in any state SHALL force IDLE on the same edge link_up clears and clear the pending flag and the phase timer.
REQ-026 Ports SHALL be fully independent; simultaneous events on different ports SHALL not interact.

Reset
REQ-027 rst_n low SHALL immediately clear the synchronizers, debounce counters, link_up, led, drop_cnt, pending flags and phase timers, and set all FSMs to IDLE.
REQ-028 Outputs SHALL remain 0 after rst_n deasserts until the debounce and FSM conditions are met anew.
REQ-029 Reset asserted mid-blink or mid-debounce SHALL abort that activity with no residual state.

Verification (LOCK_DEBOUNCE=4, BLINK_CYCLES=3)
REQ-030 Lock up: block_lock[0]=1 sampled from edge 0 -> link_up[0]=1 and led[0]=1 from edge 6; other ports stay 0.
REQ-031 Glitch: block_lock[1] high 3 cycles, low 1 cycle, then high -> link_up[1] asserts 6 edges after the second rising sample; drop_cnt stays 0.
REQ-032 Drop and saturation: 300 up/down cycles on port 2 -> drop_cnt[23:16]=255.
REQ-033 Clear: drop_cnt_clear coincident with a port 2 drop -> drop_cnt[23:16]=1.
REQ-034 Blink: link up on port 3, single rx_activity[3] pulse at edge 0 -> led[7] high for 3 cycles, low 3 cycles, then IDLE.
REQ-035 Pending and link loss: second rx_activity[3] pulse during OFF -> ON re-enters immediately after OFF; a link drop during ON -> led[7]=0 on the same edge link_up[3] clears.
REQ-036 Reset mid-operation: rst_n pulled low mid-blink -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sfp_link_led_ctrl_if.sv
// Signal bundle for the SFP link/activity LED controller.
interface sfp_link_led_ctrl_if;
  logic [3:0]  block_lock;
  logic [3:0]  rx_activity;
  logic        drop_cnt_clear;
  logic [3:0]  link_up;
  logic [7:0]  led;
  logic [31:0] drop_cnt;

  modport master (
    output block_lock, rx_activity, drop_cnt_clear,
    input  link_up, led, drop_cnt
  );

  modport slave (
    input  block_lock, rx_activity, drop_cnt_clear,
    output link_up, led, drop_cnt
  );
endinterface

// File: rtl/sfp_link_led_ctrl.sv
// Four-port SFP link debounce, link-drop counters and activity LED blinker.
module sfp_link_led_ctrl #(
  parameter int unsigned LOCK_DEBOUNCE = 1024,
  parameter int unsigned BLINK_CYCLES  = 7812500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sfp_link_led_ctrl_if.slave   bus
);

  localparam logic [15:0] DEB_MAX    = 16'(LOCK_DEBOUNCE);
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} blink_e;

  logic [3:0]  sync1_q, sync2_q;
  logic [15:0] deb_cnt_q [4];
  logic [3:0]  link_q;
  logic [3:0]  link_fall;
  logic [7:0]  drop_q [4];
  blink_e      state_q [4];
  blink_e      state_d [4];
  logic [23:0] timer_q [4];
  logic [23:0] timer_d [4];
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  blink_q;

  // Link drops the moment the synchronized lock is seen low; no falling debounce.
  assign link_fall = link_q & ~sync2_q;

  // Two-flop synchronizer for the asynchronous block_lock inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.block_lock;
      sync2_q <= sync1_q;
    end
  end

  // Rising-side debounce: link asserts after LOCK_DEBOUNCE consecutive high samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      link_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!sync2_q[i]) begin
          deb_cnt_q[i] <= '0;
          link_q[i]    <= 1'b0;
        end else if (!link_q[i]) begin
          if (deb_cnt_q[i] == DEB_MAX) link_q[i] <= 1'b1;
          else                         deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Saturating per-port link-drop counters; a drop coincident with clear leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) drop_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.drop_cnt_clear)
          drop_q[i] <= link_fall[i] ? 8'd1 : 8'd0;
        else if (link_fall[i] && (drop_q[i] != 8'hFF))
          drop_q[i] <= drop_q[i] + 8'd1;
      end
    end
  end

  // Blink FSM state, phase timer, pending flag and registered LED bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      pend_q  <= '0;
      blink_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        blink_q[i] <= (state_d[i] == ON);
      end
      pend_q <= pend_d;
    end
  end

  // Blink FSM next state: ON and OFF each last BLINK_CYCLES; link loss forces IDLE.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
    end
    pend_d = pend_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (link_fall[i]) begin
        state_d[i] = IDLE;
        timer_d[i] = '0;
        pend_d[i]  = 1'b0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (bus.rx_activity[i] && link_q[i]) begin
              state_d[i] = ON;
              timer_d[i] = '0;
              pend_d[i]  = 1'b0;
            end
          end
          ON: begin
            if (bus.rx_activity[i] && link_q[i]) pend_d[i] = 1'b1;
            if (timer_q[i] == BLINK_LAST) begin
              state_d[i] = OFF;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 24'd1;
            end
          end
          OFF: begin
            // A pulse on the final OFF cycle counts as pending, so it re-enters ON.
            if (timer_q[i] == BLINK_LAST) begin
              timer_d[i] = '0;
              pend_d[i]  = 1'b0;
              if (pend_q[i] || (bus.rx_activity[i] && link_q[i])) state_d[i] = ON;
              else                                                 state_d[i] = IDLE;
            end else begin
              timer_d[i] = timer_q[i] + 24'd1;
              if (bus.rx_activity[i] && link_q[i]) pend_d[i] = 1'b1;
            end
          end
          default: begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
            pend_d[i]  = 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.link_up  = link_q;
  assign bus.led      = {blink_q, link_q};
  assign bus.drop_cnt = {drop_q[3], drop_q[2], drop_q[1], drop_q[0]};

endmodule
